sbus_arbiter2: RTL and testbench
================================

Name: sbus_arbiter2

Overview:
- Two-master to one-slave arbiter for the sbus protocol.
- Sits directly upstream of the sbus-to-SRAM bridge, so instruction fetch (m0) and data access (m1) share one single-ported SRAM.
- Selects one master per cycle, forwards its request unchanged, stalls the loser, and routes the one-cycle-late read data back to the master that issued it.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate on contention; 0 = fixed priority, m0 always wins.
- HOLD_ON_STALL, 1, 1 = grant is locked to the current owner while the slave asserts stall.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- m0  sbus.slave  if  master 0 (instruction side): en, we, size[1:0], addr[31:0], data_w[31:0] in; data_r[31:0], stall out.
- m1  sbus.slave  if  master 1 (data side), same fields.
- s  sbus.master  if  downstream slave: en, we, size, addr, data_w out; data_r, stall in.

Behaviour:
- Shared sbus rules:
  - A request is en=1. It is accepted in a cycle with en=1 and stall=0.
  - The master holds all request fields stable while stall=1.
  - Read data is valid on data_r in the cycle after acceptance.
- State registers: last_gnt (1b), lock (1b), lock_id (1b), rsp_id (1b), rsp_vld (1b).
- Reset (rst=0, asynchronous) values: last_gnt=1 (so m0 wins first contention), lock=0, lock_id=0, rsp_id=0, rsp_vld=0.
- Outputs during reset: s.en=0; mi.stall=mi.en; mi.data_r=0.
- Grant selection (combinational), gnt_id / gnt_vld:
  - If lock=1: gnt_id=lock_id.
  - Else if only one mi.en=1: that master.
  - Else if both requesting: m0 when ROUND_ROBIN=0; ~last_gnt when ROUND_ROBIN=1.
  - gnt_vld = the granted master's en.
- Forwarding: s.{en,we,size,addr,data_w} = fields of the granted master when gnt_vld, else all zero. Zero added latency on the request path.
- Stalls:
  - m_gnt.stall = s.stall.
  - The non-granted master gets stall = its en (a stalled loser is not accepted).
  - A master with en=0 always sees stall=0.
- Lock (HOLD_ON_STALL=1):
  - If s.en=1 and s.stall=1: lock<=1, lock_id<=gnt_id.
  - If s.stall=0: lock<=0.
  - This guarantees the slave never sees the request switch masters mid-stall.
  - With HOLD_ON_STALL=0, lock stays 0.
- On acceptance (s.en & ~s.stall):
  - last_gnt <= gnt_id, rsp_id <= gnt_id, rsp_vld <= 1.
  - Writes also set rsp_vld, which is harmless because data_r is ignored on writes.
- Otherwise rsp_vld <= 0.
- Read return: mi.data_r = s.data_r when rsp_vld and rsp_id==i, else 32'h0.
  - Back-to-back acceptances from alternating masters each get their own data in the following cycle; no buffering is needed because the slave has a fixed 1-cycle latency.
- Starvation: under ROUND_ROBIN=1 with both masters requesting every cycle, grants strictly alternate m0, m1, m0, …
- Master dropping en while locked: not legal per the sbus rules. If it happens anyway, s.en=0 that cycle and lock clears when s.stall falls.
- Reset asserted mid-transaction: the pending response is discarded (rsp_vld=0) and the next grant after release goes to m0.

Test Plan:
- Single master: m1 reads addr 0x100 with m0 idle → s.addr=0x100 same cycle, m1.stall=0, next cycle m1.data_r = s.data_r (e.g. 0xDEADBEEF), m0.data_r=0.
- Contention, RR: both request continuously for 4 cycles after reset → grants m0,m1,m0,m1; loser stall=1 each cycle; each data_r lands on the correct master one cycle later.
- Fixed priority (ROUND_ROBIN=0): both request for 3 cycles → m0 granted all 3, m1.stall=1 throughout; m1 granted in the first cycle m0.en=0.
- Slave stall lock: m1 granted, s.stall=1 for 2 cycles while m0 also requests → s.addr stays m1's address, m0.stall=1; after stall drops m1 is accepted, then m0 is granted the following cycle.
- Write pass-through: m0 write size=2'b00, addr 0x203, data_w=0xAB → s.we=1, s.size=0, s.addr=0x203, s.data_w=0xAB unchanged; m0.stall=0.
- Async reset: assert rst=0 between edges while lock=1 → s.en=0 immediately, lock=0; after release with both masters requesting, m0 is granted first.

Source files
------------

// File: rtl/sbus_arbiter2_if.sv
// sbus point-to-point link: one request channel (en/we/size/addr/data_w)
// and its response side (data_r one cycle after acceptance, stall).
interface sbus_arbiter2_if;
    logic        en;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data_w;
    logic [31:0] data_r;
    logic        stall;

    // Seen from the arbiter's upstream side: the master drives the request.
    modport slave (
        input  en, we, size, addr, data_w,
        output data_r, stall
    );

    // Seen from the arbiter's downstream side: the arbiter drives the request.
    modport master (
        output en, we, size, addr, data_w,
        input  data_r, stall
    );
endinterface

// File: rtl/sbus_arbiter2.sv
// Two-master sbus arbiter in front of a single-ported SRAM bridge.
// m0 = instruction fetch, m1 = data access. One master is granted per
// cycle and its request is forwarded combinationally; the loser is stalled.
// Read data returns one cycle after acceptance and is steered back to the
// master that issued it. While the slave stalls, the grant is locked to the
// current owner so the slave never sees the request change hands mid-stall.
module sbus_arbiter2 #(
    parameter int ROUND_ROBIN   = 1,  // 1: alternate on contention, 0: m0 always wins
    parameter int HOLD_ON_STALL = 1   // 1: keep grant on owner while slave stalls
) (
    input logic           clk,
    input logic           rst,    // asynchronous, active low
    sbus_arbiter2_if.slave  m0,
    sbus_arbiter2_if.slave  m1,
    sbus_arbiter2_if.master s
);

    localparam int NUM_M = 2;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data_w;
    } req_t;

    req_t [NUM_M-1:0] req;
    req_t             fwd;

    logic in_rst;
    logic gnt_id;
    logic gnt_vld;
    logic accept;

    logic last_gnt_q, last_gnt_d;
    logic lock_q,     lock_d;
    logic lock_id_q,  lock_id_d;
    logic rsp_id_q,   rsp_id_d;
    logic rsp_vld_q,  rsp_vld_d;

    logic [NUM_M-1:0]       m_stall;
    logic [NUM_M-1:0][31:0] m_data_r;

    assign req[0] = {m0.en, m0.we, m0.size, m0.addr, m0.data_w};
    assign req[1] = {m1.en, m1.we, m1.size, m1.addr, m1.data_w};

    // While reset is held nothing is forwarded, regardless of master requests.
    assign in_rst = ~rst;

    // Pick the master for this cycle: lock owner first, then sole requester,
    // then the contention policy.
    always_comb begin
        gnt_id = 1'b0;
        if (lock_q) begin
            gnt_id = lock_id_q;
        end else if (req[0].en && !req[1].en) begin
            gnt_id = 1'b0;
        end else if (!req[0].en && req[1].en) begin
            gnt_id = 1'b1;
        end else if (req[0].en && req[1].en) begin
            gnt_id = (ROUND_ROBIN != 0) ? ~last_gnt_q : 1'b0;
        end
        // A locked owner that dropped en yields an idle slot, not a switch.
        gnt_vld = req[gnt_id].en & ~in_rst;
    end

    // Forward the granted request unchanged; idle bus is all zero.
    assign fwd      = gnt_vld ? req[gnt_id] : '0;
    assign s.en     = fwd.en;
    assign s.we     = fwd.we;
    assign s.size   = fwd.size;
    assign s.addr   = fwd.addr;
    assign s.data_w = fwd.data_w;

    assign accept = fwd.en & ~s.stall;

    // Next-state for lock, fairness pointer and response routing.
    always_comb begin
        last_gnt_d = last_gnt_q;
        lock_d     = lock_q;
        lock_id_d  = lock_id_q;
        rsp_id_d   = rsp_id_q;
        rsp_vld_d  = 1'b0;
        if (HOLD_ON_STALL != 0) begin
            if (fwd.en && s.stall) begin
                lock_d    = 1'b1;
                lock_id_d = gnt_id;
            end else if (!s.stall) begin
                lock_d = 1'b0;
            end
        end else begin
            lock_d = 1'b0;
        end
        // Writes also mark a response slot; nobody looks at data_r for them.
        if (accept) begin
            last_gnt_d = gnt_id;
            rsp_id_d   = gnt_id;
            rsp_vld_d  = 1'b1;
        end
    end

    // State flops; last_gnt resets to 1 so m0 wins the first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_q <= 1'b1;
            lock_q     <= 1'b0;
            lock_id_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_vld_q  <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            rsp_id_q   <= rsp_id_d;
            rsp_vld_q  <= rsp_vld_d;
        end
    end

    // Per-master stall and read-data steering.
    for (genvar i = 0; i < NUM_M; i++) begin : g_mst
        localparam logic ID = 1'(i);
        // Granted master mirrors the slave stall; a requesting loser is held
        // off; an idle master is never stalled.
        assign m_stall[i]  = req[i].en & ((gnt_vld && gnt_id == ID) ? s.stall : 1'b1);
        // Fixed one-cycle slave latency: the slot after acceptance is ours.
        assign m_data_r[i] = (rsp_vld_q && rsp_id_q == ID) ? s.data_r : 32'h0;
    end

    assign m0.stall  = m_stall[0];
    assign m1.stall  = m_stall[1];
    assign m0.data_r = m_data_r[0];
    assign m1.data_r = m_data_r[1];

endmodule

// File: tb/tb_sbus_arbiter2.sv
// Bench for sbus_arbiter2: three instances (round-robin+hold, fixed
// priority+hold, round-robin without hold) share one stimulus stream.
// A behavioural model tracks owner / preferred master / response target
// per instance and is compared against every output every cycle.
module tb_sbus_arbiter2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus
    logic [1:0]       m_en   = '0;
    logic [1:0]       m_we   = '0;
    logic [1:0][1:0]  m_size = '0;
    logic [1:0][31:0] m_addr = '0;
    logic [1:0][31:0] m_dw   = '0;
    logic             s_stall = 1'b0;
    logic [31:0]      s_dr    = '0;

    // collected outputs per instance
    logic        o_s_en   [3];
    logic        o_s_we   [3];
    logic [1:0]  o_s_size [3];
    logic [31:0] o_s_addr [3];
    logic [31:0] o_s_dw   [3];
    logic [1:0]  o_stall  [3];
    logic [31:0] o_dr0    [3];
    logic [31:0] o_dr1    [3];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        sbus_arbiter2_if m0_if ();
        sbus_arbiter2_if m1_if ();
        sbus_arbiter2_if s_if ();

        assign m0_if.en = m_en[0];  assign m0_if.we = m_we[0];
        assign m0_if.size = m_size[0];  assign m0_if.addr = m_addr[0];
        assign m0_if.data_w = m_dw[0];
        assign m1_if.en = m_en[1];  assign m1_if.we = m_we[1];
        assign m1_if.size = m_size[1];  assign m1_if.addr = m_addr[1];
        assign m1_if.data_w = m_dw[1];
        assign s_if.stall  = s_stall;
        assign s_if.data_r = s_dr;

        sbus_arbiter2 #(
            .ROUND_ROBIN  ((k == 1) ? 0 : 1),
            .HOLD_ON_STALL((k == 2) ? 0 : 1)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .m0 (m0_if),
            .m1 (m1_if),
            .s  (s_if)
        );

        assign o_s_en[k]   = s_if.en;
        assign o_s_we[k]   = s_if.we;
        assign o_s_size[k] = s_if.size;
        assign o_s_addr[k] = s_if.addr;
        assign o_s_dw[k]   = s_if.data_w;
        assign o_stall[k]  = {m1_if.stall, m0_if.stall};
        assign o_dr0[k]    = m0_if.data_r;
        assign o_dr1[k]    = m1_if.data_r;
    end

    // ---------------- behavioural model ----------------
    // owner: master holding the bus through a slave stall (-1 none)
    // pref : master that wins the next two-way contest
    // resp_to: master whose read data is on the bus this cycle (-1 none)
    int owner   [3] = '{-1, -1, -1};
    int pref    [3] = '{0, 0, 0};
    int resp_to [3] = '{-1, -1, -1};

    function automatic bit is_rr(int k);   return k != 1; endfunction
    function automatic bit is_hold(int k); return k != 2; endfunction

    // Which master is actually driving the slave this cycle (-1 = idle).
    function automatic int winner(int k);
        if (!rst) return -1;
        if (owner[k] >= 0) return m_en[owner[k]] ? owner[k] : -1;
        if (m_en == 2'b11) return is_rr(k) ? pref[k] : 0;
        if (m_en[0]) return 0;
        if (m_en[1]) return 1;
        return -1;
    endfunction

    function automatic int next_owner(int k);
        if (!s_stall) return -1;
        if (winner(k) >= 0) return winner(k);
        return owner[k];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                owner[k]   <= -1;
                pref[k]    <= 0;
                resp_to[k] <= -1;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (is_hold(k)) owner[k] <= next_owner(k);
                resp_to[k] <= (winner(k) >= 0 && !s_stall) ? winner(k) : -1;
                if (winner(k) >= 0 && !s_stall) pref[k] <= 1 - winner(k);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int w;
            logic [1:0] st;
            w = winner(k);
            st[0] = m_en[0] && (w != 0 || s_stall);
            st[1] = m_en[1] && (w != 1 || s_stall);
            check($sformatf("i%0d s_en", k),   32'(o_s_en[k]),   32'(w >= 0));
            check($sformatf("i%0d s_we", k),   32'(o_s_we[k]),   (w >= 0) ? 32'(m_we[w]) : 32'h0);
            check($sformatf("i%0d s_size", k), 32'(o_s_size[k]), (w >= 0) ? 32'(m_size[w]) : 32'h0);
            check($sformatf("i%0d s_addr", k), o_s_addr[k],      (w >= 0) ? m_addr[w] : 32'h0);
            check($sformatf("i%0d s_dw", k),   o_s_dw[k],        (w >= 0) ? m_dw[w] : 32'h0);
            check($sformatf("i%0d stall", k),  32'(o_stall[k]),  32'(st));
            check($sformatf("i%0d dr0", k),    o_dr0[k],         (resp_to[k] == 0) ? s_dr : 32'h0);
            check($sformatf("i%0d dr1", k),    o_dr1[k],         (resp_to[k] == 1) ? s_dr : 32'h0);
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus + literal expectations ----------------
    initial begin
        // reset held, both masters requesting
        m_en = 2'b11; m_addr[0] = 32'h10; m_addr[1] = 32'h20;
        @(negedge clk);
        check("rst s_en",  32'(o_s_en[0]),  32'h0);
        check("rst stall", 32'(o_stall[0]), 32'h3);
        check("rst dr1",   o_dr1[0],        32'h0);

        // single master read from m1
        next_cyc();
        rst = 1'b1;
        m_en = 2'b10; m_we = 2'b00; m_addr[1] = 32'h100;
        @(negedge clk);
        check("single addr",  o_s_addr[0],       32'h100);
        check("single en",    32'(o_s_en[0]),    32'h1);
        check("single stall", 32'(o_stall[0]),   32'h0);
        next_cyc();
        m_en = 2'b00; s_dr = 32'hDEADBEEF;
        @(negedge clk);
        check("single dr1", o_dr1[0], 32'hDEADBEEF);
        check("single dr0", o_dr0[0], 32'h0);

        // contention: RR alternates, fixed priority always m0
        m_addr[0] = 32'h1000; m_addr[1] = 32'h2000;
        for (int c = 0; c < 4; c++) begin
            next_cyc();
            m_en = 2'b11; s_dr = 32'hD0 + 32'(c);
            @(negedge clk);
            check($sformatf("rr addr c%0d", c), o_s_addr[0], (c % 2 == 0) ? 32'h1000 : 32'h2000);
            check($sformatf("rr stall c%0d", c), 32'(o_stall[0]), (c % 2 == 0) ? 32'h2 : 32'h1);
            check($sformatf("rr dr0 c%0d", c), o_dr0[0], (c % 2 == 1) ? s_dr : 32'h0);
            check($sformatf("rr dr1 c%0d", c), o_dr1[0], (c > 0 && c % 2 == 0) ? s_dr : 32'h0);
            check($sformatf("fp addr c%0d", c), o_s_addr[1], 32'h1000);
            check($sformatf("fp stall c%0d", c), 32'(o_stall[1]), 32'h2);
        end
        next_cyc();
        m_en = 2'b10;
        @(negedge clk);
        check("fp m1 addr",  o_s_addr[1],     32'h2000);
        check("fp m1 stall", 32'(o_stall[1]), 32'h0);

        // slave stall lock on m1 while m0 shows up
        next_cyc();
        m_en = 2'b10; m_addr[1] = 32'h300; s_stall = 1'b1;
        @(negedge clk);
        check("lock addr0",  o_s_addr[0],     32'h300);
        check("lock stall0", 32'(o_stall[0]), 32'h2);
        for (int c = 0; c < 2; c++) begin
            next_cyc();
            m_en = 2'b11; m_addr[0] = 32'h400;
            @(negedge clk);
            check($sformatf("lock addr c%0d", c),  o_s_addr[0],     32'h300);
            check($sformatf("lock stall c%0d", c), 32'(o_stall[0]), 32'h3);
        end
        next_cyc();
        s_stall = 1'b0;
        @(negedge clk);
        check("unlock addr",  o_s_addr[0],     32'h300);
        check("unlock stall", 32'(o_stall[0]), 32'h1);
        next_cyc();
        m_addr[1] = 32'h304;
        @(negedge clk);
        check("after lock addr",  o_s_addr[0],     32'h400);
        check("after lock stall", 32'(o_stall[0]), 32'h2);

        // write pass-through from m0
        next_cyc();
        m_en = 2'b01; m_we = 2'b01; m_size[0] = 2'b00; m_addr[0] = 32'h203; m_dw[0] = 32'hAB;
        @(negedge clk);
        check("wr we",    32'(o_s_we[0]),   32'h1);
        check("wr size",  32'(o_s_size[0]), 32'h0);
        check("wr addr",  o_s_addr[0],      32'h203);
        check("wr data",  o_s_dw[0],        32'hAB);
        check("wr stall", 32'(o_stall[0]),  32'h0);

        // async reset while locked
        next_cyc();
        m_we = 2'b00; m_en = 2'b10; m_addr[1] = 32'h500; s_stall = 1'b1;
        next_cyc();
        m_en = 2'b11; m_addr[0] = 32'h600;
        #2 rst = 1'b0;
        #1;
        check("arst s_en",  32'(o_s_en[0]),  32'h0);
        check("arst stall", 32'(o_stall[0]), 32'h3);
        @(posedge clk);
        #2 rst = 1'b1; s_stall = 1'b0;
        @(negedge clk);
        check("post rst addr",  o_s_addr[0],     32'h600);
        check("post rst stall", 32'(o_stall[0]), 32'h2);

        // randomized traffic with occasional mid-cycle reset pulses
        for (int n = 0; n < 3000; n++) begin
            next_cyc();
            for (int i = 0; i < 2; i++) begin
                m_en[i]   = ($urandom_range(0, 9) < 7);
                m_we[i]   = 1'($urandom);
                m_size[i] = 2'($urandom);
                m_addr[i] = $urandom;
                m_dw[i]   = $urandom;
            end
            s_stall = ($urandom_range(0, 9) < 3);
            s_dr    = $urandom;
            if ($urandom_range(0, 63) == 0) begin
                #2 rst = 1'b0;
                @(posedge clk);
                #6 rst = 1'b1;
            end
        end

        next_cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
